// File: rtl/vid_ram_rd_arb.sv
// vid_ram_rd_arb: shares one AXI4 read port between the CPU (m0)
// and scanout DMA (m1); video wins, a counter bounds CPU starvation.
module vid_ram_rd_arb #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [1:0]            s0_arburst,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [1:0]            s1_arburst,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic [3:0] starve_q, starve_d;
  logic       pick;

  // State, grant and starvation counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      starve_q <= starve_d;
    end
  end

  // Video wins a tie unless the CPU has waited out the limit
  always_comb begin
    pick = s1_arvalid;
    if (s0_arvalid && s1_arvalid && starve_q >= LIMIT)
      pick = 1'b0;
  end

  // Next-state, grant load and starvation bookkeeping
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (s0_arvalid || s1_arvalid) begin
          state_d = ADDR;
          grant_d = pick;
          if (!pick)
            starve_d = 4'd0;
          else if (s0_arvalid && starve_q < LIMIT)
            starve_d = starve_q + 4'd1;
        end
      end
      ADDR: begin
        if (m_arvalid && m_arready)
          state_d = DATA;
      end
      DATA: begin
        if (m_rvalid && m_rready && m_rlast)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake routing by state and registered grant
  always_comb begin
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    unique case (state_q)
      ADDR: begin
        m_arvalid  = grant_q ? s1_arvalid : s0_arvalid;
        s0_arready = !grant_q && m_arready;
        s1_arready = grant_q && m_arready;
      end
      DATA: begin
        m_rready  = grant_q ? s1_rready : s0_rready;
        s0_rvalid = !grant_q && m_rvalid;
        s1_rvalid = grant_q && m_rvalid;
      end
      default: begin
        m_arvalid = 1'b0;
      end
    endcase
  end

  // AR fields follow the granted master at all times
  always_comb begin
    m_araddr  = grant_q ? s1_araddr  : s0_araddr;
    m_arlen   = grant_q ? s1_arlen   : s0_arlen;
    m_arsize  = grant_q ? s1_arsize  : s0_arsize;
    m_arburst = grant_q ? s1_arburst : s0_arburst;
  end

  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s1_rresp = m_rresp;
  assign s0_rlast = m_rlast;
  assign s1_rlast = m_rlast;

endmodule
